// File: rtl/bus_xfer_sched.sv
// Register-to-register transfer scheduler for the shared datapath bus.
// Queues (src, dst) requests and issues pipelined one-hot Read/Write enables with RAW stalls.
module bus_xfer_sched #(
    parameter int unsigned N_REGS  = 16,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned Q_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [SEL_W-1:0]             req_src,
    input  logic [SEL_W-1:0]             req_dst,
    output logic [N_REGS-1:0]            rd_en,
    output logic [N_REGS-1:0]            wr_en,
    output logic                         xfer_done,
    output logic                         req_err,
    output logic [$clog2(Q_DEPTH):0]     q_count,
    output logic                         busy
);

    localparam int unsigned PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(Q_DEPTH) + 1;

    typedef struct packed {
        logic [SEL_W-1:0] src;
        logic [SEL_W-1:0] dst;
    } xfer_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    xfer_t              mem [Q_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_d;
    logic [SEL_W-1:0]   cur_dst_q, cur_dst_d;
    logic [SEL_W-1:0]   pend_dst_q, pend_dst_d;
    logic               pend_v_q, pend_v_d;
    logic [N_REGS-1:0]  rd_d, wr_d;
    logic               done_d;

    logic               req_fire, req_bad, req_ok;
    logic               fifo_empty, head_v, pop, pop_fifo, push;
    xfer_t              incoming, head;

    function automatic logic [N_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        sel_onehot = N_REGS'(1) << s;
    endfunction

    // Request acceptance; an empty FIFO lets a fresh request bypass straight to the FSM.
    assign req_fire   = req_valid && req_ready;
    assign req_bad    = (32'(req_src) >= N_REGS) || (32'(req_dst) >= N_REGS);
    assign req_ok     = req_fire && !req_bad;
    assign fifo_empty = (q_count == CNT_W'(0));
    assign incoming   = '{src: req_src, dst: req_dst};
    assign head_v     = !fifo_empty || req_ok;
    assign head       = fifo_empty ? incoming : mem[rd_ptr_q];
    assign pop_fifo   = pop && !fifo_empty;
    assign push       = req_ok && !(pop && fifo_empty);

    always_comb begin
        unique case ({push, pop_fifo})
            2'b10:   count_d = q_count + CNT_W'(1);
            2'b01:   count_d = q_count - CNT_W'(1);
            default: count_d = q_count;
        endcase
    end

    // Next-state and registered-output decode; enables are for the cycle after the edge.
    always_comb begin
        state_d    = state_q;
        cur_dst_d  = cur_dst_q;
        pend_v_d   = 1'b0;
        pend_dst_d = pend_dst_q;
        pop        = 1'b0;
        rd_d       = '0;
        wr_d       = '0;
        done_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (head_v) begin
                    pop       = 1'b1;
                    cur_dst_d = head.dst;
                    rd_d      = sel_onehot(head.src);
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_WRITE;
                wr_d    = sel_onehot(cur_dst_q);
                if (head_v && (head.src != cur_dst_q)) begin
                    pop        = 1'b1;
                    pend_v_d   = 1'b1;
                    pend_dst_d = head.dst;
                    rd_d       = sel_onehot(head.src);
                end
            end
            ST_WRITE: begin
                done_d = 1'b1;
                if (pend_v_q) begin
                    cur_dst_d = pend_dst_q;
                    wr_d      = sel_onehot(pend_dst_q);
                    if (head_v && (head.src != pend_dst_q)) begin
                        pop        = 1'b1;
                        pend_v_d   = 1'b1;
                        pend_dst_d = head.dst;
                        rd_d       = sel_onehot(head.src);
                    end
                end else if (head_v) begin
                    // Either the FIFO refilled or the head was held back by a RAW hazard.
                    pop       = 1'b1;
                    cur_dst_d = head.dst;
                    rd_d      = sel_onehot(head.src);
                    state_d   = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_dst_q  <= '0;
            pend_dst_q <= '0;
            pend_v_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            q_count    <= '0;
            rd_en      <= '0;
            wr_en      <= '0;
            xfer_done  <= 1'b0;
            req_err    <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cur_dst_q  <= cur_dst_d;
            pend_dst_q <= pend_dst_d;
            pend_v_q   <= pend_v_d;
            if (push)     wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_fifo) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            q_count    <= count_d;
            rd_en      <= rd_d;
            wr_en      <= wr_d;
            xfer_done  <= done_d;
            req_err    <= req_fire && req_bad;
            busy       <= (state_d != ST_IDLE) || (count_d != CNT_W'(0));
            req_ready  <= (count_d != CNT_W'(Q_DEPTH));
        end
    end

    // Request storage; contents are don't-care until pointed at by a valid entry.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= incoming;
    end

endmodule

// File: tb/tb_bus_xfer_sched.sv
// Directed bench for bus_xfer_sched with a bus-register model and an in-order transfer scoreboard.
module tb_bus_xfer_sched;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_src;
    logic [4:0]  req_dst;
    logic [15:0] rd_en;
    logic [15:0] wr_en;
    logic        xfer_done;
    logic        req_err;
    logic [2:0]  q_count;
    logic        busy;

    bus_xfer_sched #(.N_REGS(16), .SEL_W(5), .Q_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .xfer_done (xfer_done),
        .req_err   (req_err),
        .q_count   (q_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] src;
        logic [3:0] dst;
    } ent_t;

    ent_t        sb [$];
    int          wr_cycles [$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          prev_wr  = 1'b0;
    logic [3:0]  last_dst = '0;
    logic [7:0]  ref_regs [16];
    logic [7:0]  bregs [16];
    logic [7:0]  bus_q;
    logic        preload;

    function automatic logic [7:0] init_val(input int i);
        if (i == 1) return 8'h3C;
        if (i == 2) return 8'hA7;
        return 8'(i * 17 + 5);
    endfunction

    // Bus registers: data appears on the bus the cycle after Read, captured on Write.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) bregs[i] <= init_val(i);
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (rd_en[i]) bus_q <= bregs[i];
                if (wr_en[i]) bregs[i] <= bus_q;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic acc;
        logic err_exp;
        ent_t e;
        err_exp = 1'b0;
        acc = rst_n && req_valid && req_ready;
        if (acc) begin
            if (req_src >= 5'd16 || req_dst >= 5'd16) err_exp = 1'b1;
            else sb.push_back('{src: req_src[3:0], dst: req_dst[3:0]});
        end
        @(posedge clk);
        #1;
        cyc++;
        check("req_err", 32'(req_err), 32'(err_exp));
        check("rd_onehot0", 32'($onehot0(rd_en)), 32'd1);
        check("wr_onehot0", 32'($onehot0(wr_en)), 32'd1);
        check("xfer_done", 32'(xfer_done), 32'(prev_wr));
        if (xfer_done && prev_wr)
            check("dst_data", 32'(bregs[last_dst]), 32'(ref_regs[last_dst]));
        prev_wr = (wr_en != '0);
        if (wr_en != '0) begin
            wr_cycles.push_back(cyc);
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(wr_en), 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_en_dst", 32'(wr_en), 32'(16'(1) << e.dst));
                ref_regs[e.dst] = ref_regs[e.src];
                last_dst = e.dst;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_preload();
        preload = 1'b1;
        step();
        preload = 1'b0;
        for (int i = 0; i < 16; i++) ref_regs[i] = init_val(i);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while ((busy || xfer_done) && i < 40) begin
            step();
            i++;
        end
        check(tag, 32'(busy || xfer_done), 32'd0);
    endtask

    task automatic drive(input logic [4:0] s, input logic [4:0] d);
        req_valid = 1'b1;
        req_src   = s;
        req_dst   = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        preload   = 1'b0;
        for (int i = 0; i < 16; i++) ref_regs[i] = init_val(i);
        drive(5'd3, 5'd4);
        @(negedge clk);

        // Reset values with a request held
        step();
        step();
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_qcount", 32'(q_count), 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("post_rst_rd_en", 32'(rd_en), 32'd0);
        check("post_rst_qcount", 32'(q_count), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        do_preload();

        // Single transfer 2 -> 5
        drive(5'd2, 5'd5);
        step();
        req_valid = 1'b0;
        check("t2_rd_en", 32'(rd_en), 32'h0004);
        check("t2_wr_idle", 32'(wr_en), 32'h0000);
        step();
        check("t2_wr_en", 32'(wr_en), 32'h0020);
        check("t2_rd_idle", 32'(rd_en), 32'h0000);
        step();
        check("t2_done", 32'(xfer_done), 32'd1);
        check("t2_reg5", 32'(bregs[5]), 32'h00A7);
        wait_idle("t2_idle");

        // Back-to-back independent transfers
        wr_cycles.delete();
        drive(5'd1, 5'd2); step();
        drive(5'd3, 5'd4); step();
        drive(5'd5, 5'd6); step();
        drive(5'd7, 5'd8); step();
        req_valid = 1'b0;
        wait_idle("t3_idle");
        check("t3_wr_count", 32'(wr_cycles.size()), 32'd4);
        if (wr_cycles.size() == 4)
            check("t3_no_bubble", 32'(wr_cycles[3] - wr_cycles[0]), 32'd3);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // RAW hazard 1 -> 2 then 2 -> 3
        do_preload();
        wr_cycles.delete();
        drive(5'd1, 5'd2); step();
        drive(5'd2, 5'd3); step();
        req_valid = 1'b0;
        wait_idle("t4_idle");
        check("t4_wr_count", 32'(wr_cycles.size()), 32'd2);
        if (wr_cycles.size() == 2)
            check("t4_bubble", 32'(wr_cycles[1] - wr_cycles[0]), 32'd2);
        check("t4_reg3", 32'(bregs[3]), 32'h003C);

        // Fill the FIFO with self-hazarding requests
        drive(5'd1, 5'd1);
        for (int i = 0; i < 40 && q_count != 3'd4; i++) step();
        check("t5_qcount_full", 32'(q_count), 32'd4);
        check("t5_ready_full", 32'(req_ready), 32'd0);
        check("t5_busy_full", 32'(busy), 32'd1);
        step();
        req_valid = 1'b0;
        wait_idle("t5_drain");
        check("t5_sb_empty", 32'(sb.size()), 32'd0);
        check("t5_qcount_drained", 32'(q_count), 32'd0);

        // Out-of-range selects from idle
        drive(5'd16, 5'd3);
        step();
        req_valid = 1'b0;
        check("t5_err_src", 32'(req_err), 32'd1);
        check("t5_err_qcount", 32'(q_count), 32'd0);
        check("t5_err_rd", 32'(rd_en), 32'd0);
        drive(5'd3, 5'd16);
        step();
        req_valid = 1'b0;
        check("t5_err_dst", 32'(req_err), 32'd1);
        check("t5_err_busy", 32'(busy), 32'd0);
        step();
        check("t5_err_pulse", 32'(req_err), 32'd0);

        // Reset during a READ cycle with an entry still queued
        drive(5'd4, 5'd6); step();
        drive(5'd6, 5'd7); step();
        drive(5'd8, 5'd9); step();
        req_valid = 1'b0;
        check("t6_rd_before", 32'(rd_en), 32'h0040);
        check("t6_q_before", 32'(q_count), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rd_async", 32'(rd_en), 32'd0);
        check("t6_q_async", 32'(q_count), 32'd0);
        check("t6_ready_async", 32'(req_ready), 32'd1);
        sb.delete();
        prev_wr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t6_no_wr", 32'(wr_en), 32'd0);
            check("t6_qcount", 32'(q_count), 32'd0);
        end
        check("t6_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
